keypad_scanner: RTL and testbench
=================================

KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 The block SHALL have parameter SCAN_DIV, default 100_000, meaning clocks per scan tick (1 kHz at 100 MHz); legal range >= 2.
REQ-002 The block SHALL have parameter DEBOUNCE_TICKS, default 4, meaning consecutive stable tick samples required for press or release; legal range >= 1.
REQ-003 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-004 The block SHALL have port clk, input, 1 bit: system clock, rising edge.
REQ-005 The block SHALL have port reset_n, input, 1 bit: asynchronous active-low reset.
REQ-006 The block SHALL have port row, input, 4 bits: keypad rows, active-low, asynchronous to clk, externally pulled up.
REQ-007 The block SHALL have port col, output, 4 bits: column strobe, one bit low at a time, in the order 1110, 1101, 1011, 0111.
REQ-008 The block SHALL have port key_code, output, 4 bits: hex code of the last debounced key.
REQ-009 The block SHALL have port key_valid, output, 1 bit: one-clock pulse per debounced press.
REQ-010 The block SHALL have port key_held, output, 1 bit: high while the debounced key remains pressed.
REQ-011 The block SHALL have port digits, output, 16 bits: four packed BCD entry digits, [3:0] least significant, ready for the 4-digit display path.

Function
REQ-012 row SHALL pass through a 2-flop synchronizer; all decisions use the synchronized value.
REQ-013 A tick SHALL occur on the cycle the divider reaches SCAN_DIV-1; the divider then wraps to 0.
REQ-014 Key map by (row r, col c): r0 = 1,2,3,A; r1 = 4,5,6,B; r2 = 7,8,9,C; r3 = E(*),0,F(#),D.
REQ-015 FSM state SCAN: on each tick, if no row is low, col SHALL advance to the next column, wrapping 0111 to 1110.
REQ-016 In SCAN, a tick with any row low SHALL latch the column and the lowest-index low row, freeze col, and enter DEBOUNCE with count 1.
REQ-017 In DEBOUNCE, each tick with the latched row low SHALL increment the count; a tick with that row high SHALL return the FSM to SCAN with no output.
REQ-018 When the count reaches DEBOUNCE_TICKS, the block SHALL update key_code, pulse key_valid high for exactly one clock, and enter HELD.
REQ-019 With DEBOUNCE_TICKS=1, the press tick itself SHALL produce key_valid on the following clock.
REQ-020 In HELD, key_held SHALL be 1 and col SHALL stay frozen; DEBOUNCE_TICKS consecutive ticks with the latched row high SHALL enter SCAN; any low tick restarts the release count.
REQ-021 key_held SHALL be 0 in SCAN and DEBOUNCE; holding a key SHALL NOT repeat key_valid.
REQ-022 A second key pressed while in HELD SHALL be ignored until release completes.
REQ-023 On a key_valid for code 0-9, digits SHALL become {digits[11:0], code}, discarding the oldest digit.
REQ-024 On a key_valid for code E, digits SHALL become 16'h0000.
REQ-025 All other codes SHALL leave digits unchanged.
REQ-026 key_code SHALL hold its value until the next key_valid.

Reset
REQ-027 While reset_n is low, the block SHALL force: state SCAN, col 4'b1110, key_code 0, key_valid 0, key_held 0, digits 16'h0000, divider, debounce count and synchronizer all 0 (synchronizer flops to 4'b1111).
REQ-028 A reset mid-debounce or mid-hold SHALL abort without a key_valid pulse; scanning SHALL resume from col 1110 on the first tick after release.

Structure
REQ-029 Shared package keypad_pkg SHALL hold the FSM state type (SCAN, DEBOUNCE, HELD), the 16-entry key map table and the column strobe constants.
REQ-030 The tick divider SHALL be the sub-module tick_gen (parameter SCAN_DIV, outputs a one-cycle tick).
REQ-031 The implementation SHALL be synchronous single-clock logic with no latches.

Verification
REQ-032 Benches SHALL use SCAN_DIV=4 and DEBOUNCE_TICKS=3.
REQ-033 Idle scan: no rows low -> col cycles 1110, 1101, 1011, 0111, 1110, changing every 4 clocks; key_valid stays 0.
REQ-034 Clean press: row=1101 while col=1011, held for 5 ticks -> exactly one key_valid with key_code 6, key_held 1, digits 16'h0006.
REQ-035 Bounce: row low for 2 ticks, then high -> no key_valid, FSM back to SCAN, col resumes stepping.
REQ-036 Entry and clear: keys 1, 2, 3, 4, 5 in turn -> digits 16'h2345; then * (row 0111, col 1110) -> digits 16'h0000.
REQ-037 Multiple rows and reset: rows 1010 low on column 0 -> key_code 1; assert reset_n during a later HELD -> all outputs reach their reset values and no key_valid pulse occurs.

Source files
------------

// File: rtl/keypad_pkg.sv
// ---------------------------------------------------------------------------
// keypad_pkg
// Shared definitions for the 4x4 keypad scanner: the scanner FSM state type,
// the (row, column) -> hex code key map, the column strobe patterns and a
// helper that picks the lowest-index active-low row.
// ---------------------------------------------------------------------------
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2
    } scan_state_t;

    // Indexed by {row_index, column_index}; '*' reads as E and '#' as F.
    localparam logic [3:0] KEY_MAP [0:15] = '{
        4'h1, 4'h2, 4'h3, 4'hA,
        4'h4, 4'h5, 4'h6, 4'hB,
        4'h7, 4'h8, 4'h9, 4'hC,
        4'hE, 4'h0, 4'hF, 4'hD
    };

    // One column driven low at a time, indexed by column number.
    localparam logic [3:0] COL_STROBE [0:3] = '{
        4'b1110, 4'b1101, 4'b1011, 4'b0111
    };

    // Several rows may be low at once (chorded keys); the lowest index wins.
    function automatic logic [1:0] lowest_low_row(input logic [3:0] rows);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!rows[i]) begin
                idx = 2'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/keypad_scanner_tick_gen.sv
// ---------------------------------------------------------------------------
// tick_gen
// Free-running divider producing a one-clock scan tick every SCAN_DIV clocks.
// Ports:
//   clk     - system clock, rising edge
//   reset_n - asynchronous active-low reset, clears the divider
//   tick    - high for the one cycle the divider sits at SCAN_DIV-1
// ---------------------------------------------------------------------------
module tick_gen #(
    parameter int SCAN_DIV = 100_000
) (
    input  logic clk,
    input  logic reset_n,
    output logic tick
);

    localparam int            DIV_W    = $clog2(SCAN_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] div_d;

    // The tick is decoded straight from the counter so that it lines up
    // with the cycle in which the divider wraps back to zero.
    always_comb begin
        tick  = (div_q == DIV_LAST);
        div_d = tick ? '0 : div_q + DIV_W'(1);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// ---------------------------------------------------------------------------
// keypad_scanner
// Scans a 4x4 active-low matrix keypad, debounces presses and releases on
// scan ticks, reports each debounced key once and shifts decimal keys into a
// four-digit BCD entry register ('*' clears it).
// Ports:
//   clk       - system clock, rising edge
//   reset_n   - asynchronous active-low reset
//   row       - keypad rows, active-low, asynchronous, pulled up
//   col       - column strobe, one bit low at a time
//   key_code  - hex code of the last debounced key
//   key_valid - one-clock pulse per debounced press
//   key_held  - high while the debounced key stays pressed
//   digits    - four packed BCD digits, [3:0] least significant
// ---------------------------------------------------------------------------
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV       = 100_000,
    parameter int DEBOUNCE_TICKS = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [3:0]  row,
    output logic [3:0]  col,
    output logic [3:0]  key_code,
    output logic        key_valid,
    output logic        key_held,
    output logic [15:0] digits
);

    localparam int               CNT_W    = $clog2(DEBOUNCE_TICKS + 1);
    localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DEBOUNCE_TICKS);

    logic             tick;
    logic [3:0]       sync1_q;
    logic [3:0]       sync2_q;
    scan_state_t      state_q,     state_d;
    logic [1:0]       col_idx_q,   col_idx_d;
    logic [1:0]       row_idx_q,   row_idx_d;
    logic [CNT_W-1:0] count_q,     count_d;
    logic [CNT_W-1:0] count_inc;
    logic [3:0]       col_q,       col_d;
    logic [3:0]       key_code_q,  key_code_d;
    logic             key_valid_q, key_valid_d;
    logic             key_held_q,  key_held_d;
    logic [15:0]      digits_q,    digits_d;
    logic             any_low;
    logic             latched_low;
    logic             emit;

    tick_gen #(
        .SCAN_DIV (SCAN_DIV)
    ) u_tick_gen (
        .clk     (clk),
        .reset_n (reset_n),
        .tick    (tick)
    );

    // Rows come straight off the keypad, so they are resynchronised before
    // any decision looks at them; idle (pulled-up) is all ones.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= 4'hF;
            sync2_q <= 4'hF;
        end else begin
            sync1_q <= row;
            sync2_q <= sync1_q;
        end
    end

    // Next-state logic. The FSM only moves on scan ticks; between ticks
    // every register holds except the key_valid pulse, which drops.
    // The count is reused: press confirmations in DEBOUNCE and consecutive
    // release samples in HELD.
    always_comb begin
        any_low     = (sync2_q != 4'hF);
        latched_low = ~sync2_q[row_idx_q];
        count_inc   = count_q + CNT_W'(1);

        state_d     = state_q;
        col_idx_d   = col_idx_q;
        row_idx_d   = row_idx_q;
        count_d     = count_q;
        key_code_d  = key_code_q;
        key_valid_d = 1'b0;
        digits_d    = digits_q;
        emit        = 1'b0;

        if (tick) begin
            unique case (state_q)
                SCAN: begin
                    if (any_low) begin
                        row_idx_d = lowest_low_row(sync2_q);
                        if (CNT_DONE == CNT_W'(1)) begin
                            emit    = 1'b1;
                            state_d = HELD;
                            count_d = '0;
                        end else begin
                            state_d = DEBOUNCE;
                            count_d = CNT_W'(1);
                        end
                    end else begin
                        col_idx_d = col_idx_q + 2'd1;
                    end
                end
                DEBOUNCE: begin
                    if (latched_low) begin
                        if (count_inc == CNT_DONE) begin
                            emit    = 1'b1;
                            state_d = HELD;
                            count_d = '0;
                        end else begin
                            count_d = count_inc;
                        end
                    end else begin
                        state_d = SCAN;
                        count_d = '0;
                    end
                end
                HELD: begin
                    if (latched_low) begin
                        count_d = '0;
                    end else if (count_inc == CNT_DONE) begin
                        state_d = SCAN;
                        count_d = '0;
                    end else begin
                        count_d = count_inc;
                    end
                end
                default: begin
                    state_d = SCAN;
                    count_d = '0;
                end
            endcase
        end

        // The code and the digit shift are computed from the row just
        // latched so a single-tick debounce reports the right key.
        if (emit) begin
            key_code_d  = KEY_MAP[{row_idx_d, col_idx_q}];
            key_valid_d = 1'b1;
            if (key_code_d <= 4'h9) begin
                digits_d = {digits_q[11:0], key_code_d};
            end else if (key_code_d == 4'hE) begin
                digits_d = 16'h0000;
            end
        end

        key_held_d = (state_d == HELD);
        col_d      = COL_STROBE[col_idx_d];
    end

    // State and registered outputs; a reset anywhere simply drops the
    // pending key, so no key_valid can escape from an aborted press.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= SCAN;
            col_idx_q   <= 2'd0;
            row_idx_q   <= 2'd0;
            count_q     <= '0;
            col_q       <= 4'b1110;
            key_code_q  <= 4'h0;
            key_valid_q <= 1'b0;
            key_held_q  <= 1'b0;
            digits_q    <= 16'h0000;
        end else begin
            state_q     <= state_d;
            col_idx_q   <= col_idx_d;
            row_idx_q   <= row_idx_d;
            count_q     <= count_d;
            col_q       <= col_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
            key_held_q  <= key_held_d;
            digits_q    <= digits_d;
        end
    end

    assign col       = col_q;
    assign key_code  = key_code_q;
    assign key_valid = key_valid_q;
    assign key_held  = key_held_q;
    assign digits    = digits_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// ---------------------------------------------------------------------------
// tb_keypad_scanner
// Directed bench for keypad_scanner with SCAN_DIV=4, DEBOUNCE_TICKS=3.
// Every sample point sits just after a scan-tick clock edge, so one tick is
// exactly SCAN_DIV falling edges after the previous sample point.
// ---------------------------------------------------------------------------
module tb_keypad_scanner;

    localparam int SCAN_DIV       = 4;
    localparam int DEBOUNCE_TICKS = 3;
    localparam int NUM_VEC        = 18;

    typedef struct {
        logic [3:0]  rowIn;
        int          ticks;
        logic [3:0]  expCol;
        logic [3:0]  expCode;
        logic        expValid;
        logic        expHeld;
        logic [15:0] expDigits;
        int          expPulses;
    } vector_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [3:0]  row;
    logic [3:0]  col;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_held;
    logic [15:0] digits;

    int checks     = 0;
    int errors     = 0;
    int pulseCount = 0;

    vector_t vecs [NUM_VEC];

    always #5 clk = ~clk;

    keypad_scanner #(
        .SCAN_DIV       (SCAN_DIV),
        .DEBOUNCE_TICKS (DEBOUNCE_TICKS)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .row       (row),
        .col       (col),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_held  (key_held),
        .digits    (digits)
    );

    // Counts key_valid pulses; a one-clock pulse is seen on exactly one
    // falling edge.
    always @(negedge clk) begin
        if (key_valid === 1'b1) begin
            pulseCount++;
        end
    end

    // Hard stop so a stuck run still ends.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog actual=running required=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkField(input string name, input logic [15:0] actual,
                              input logic [15:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
        end
    endtask

    task automatic checkOutput(input string tag, input logic [3:0] expCol,
                               input logic [3:0] expCode, input logic expValid,
                               input logic expHeld, input logic [15:0] expDigits);
        checkField({tag, " col"},       16'(col),       16'(expCol));
        checkField({tag, " key_code"},  16'(key_code),  16'(expCode));
        checkField({tag, " key_valid"}, 16'(key_valid), 16'(expValid));
        checkField({tag, " key_held"},  16'(key_held),  16'(expHeld));
        checkField({tag, " digits"},    digits,         expDigits);
    endtask

    task automatic stepTicks(input int n);
        repeat (n * SCAN_DIV) @(negedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [3:0] rowVal, input int n);
        row = rowVal;
        stepTicks(n);
    endtask

    // Idles until the wanted column is strobed, presses for the debounce
    // period and optionally releases for the same period.
    task automatic pressKey(input string tag, input logic [3:0] rowVal,
                            input logic [3:0] colStrobe, input logic [3:0] expCode,
                            input logic [15:0] expDigits, input logic doRelease);
        int waited;
        int p0;
        waited = 0;
        row = 4'hF;
        while (col !== colStrobe && waited < 8) begin
            stepTicks(1);
            waited++;
        end
        checkField({tag, " col ready"}, 16'(col), 16'(colStrobe));
        p0 = pulseCount;
        applyStimulus(rowVal, DEBOUNCE_TICKS);
        checkOutput({tag, " press"}, colStrobe, expCode, 1'b1, 1'b1, expDigits);
        checkField({tag, " pulses"}, 16'(pulseCount - p0), 16'd1);
        if (doRelease) begin
            applyStimulus(4'hF, DEBOUNCE_TICKS);
            checkOutput({tag, " release"}, colStrobe, expCode, 1'b0, 1'b0, expDigits);
        end
    endtask

    initial begin
        int p0;

        // Idle scan, clean press of '6' (row 1 on column 2), release, then a
        // two-tick bounce on row 0 that must not produce a key.
        vecs[0]  = '{4'hF, 1, 4'hD, 4'h0, 1'b0, 1'b0, 16'h0000, 0};
        vecs[1]  = '{4'hF, 1, 4'hB, 4'h0, 1'b0, 1'b0, 16'h0000, 0};
        vecs[2]  = '{4'hF, 1, 4'h7, 4'h0, 1'b0, 1'b0, 16'h0000, 0};
        vecs[3]  = '{4'hF, 1, 4'hE, 4'h0, 1'b0, 1'b0, 16'h0000, 0};
        vecs[4]  = '{4'hF, 1, 4'hD, 4'h0, 1'b0, 1'b0, 16'h0000, 0};
        vecs[5]  = '{4'hF, 1, 4'hB, 4'h0, 1'b0, 1'b0, 16'h0000, 0};
        vecs[6]  = '{4'hD, 1, 4'hB, 4'h0, 1'b0, 1'b0, 16'h0000, 0};
        vecs[7]  = '{4'hD, 1, 4'hB, 4'h0, 1'b0, 1'b0, 16'h0000, 0};
        vecs[8]  = '{4'hD, 1, 4'hB, 4'h6, 1'b1, 1'b1, 16'h0006, 1};
        vecs[9]  = '{4'hD, 2, 4'hB, 4'h6, 1'b0, 1'b1, 16'h0006, 0};
        vecs[10] = '{4'hF, 2, 4'hB, 4'h6, 1'b0, 1'b1, 16'h0006, 0};
        vecs[11] = '{4'hF, 1, 4'hB, 4'h6, 1'b0, 1'b0, 16'h0006, 0};
        vecs[12] = '{4'hF, 1, 4'h7, 4'h6, 1'b0, 1'b0, 16'h0006, 0};
        vecs[13] = '{4'hE, 1, 4'h7, 4'h6, 1'b0, 1'b0, 16'h0006, 0};
        vecs[14] = '{4'hE, 1, 4'h7, 4'h6, 1'b0, 1'b0, 16'h0006, 0};
        vecs[15] = '{4'hF, 1, 4'h7, 4'h6, 1'b0, 1'b0, 16'h0006, 0};
        vecs[16] = '{4'hF, 1, 4'hE, 4'h6, 1'b0, 1'b0, 16'h0006, 0};
        vecs[17] = '{4'hF, 1, 4'hD, 4'h6, 1'b0, 1'b0, 16'h0006, 0};

        reset_n = 1'b0;
        row     = 4'hF;
        repeat (3) @(negedge clk);
        #1;
        checkOutput("reset", 4'hE, 4'h0, 1'b0, 1'b0, 16'h0000);
        reset_n = 1'b1;

        for (int i = 0; i < NUM_VEC; i++) begin
            p0 = pulseCount;
            applyStimulus(vecs[i].rowIn, vecs[i].ticks);
            checkOutput($sformatf("vec%0d", i), vecs[i].expCol, vecs[i].expCode,
                        vecs[i].expValid, vecs[i].expHeld, vecs[i].expDigits);
            checkField($sformatf("vec%0d pulses", i), 16'(pulseCount - p0),
                       16'(vecs[i].expPulses));
        end

        // Digit entry 1..5 pushes the '6' out, then '*' clears.
        pressKey("key1", 4'hE, 4'hE, 4'h1, 16'h0061, 1'b1);
        pressKey("key2", 4'hE, 4'hD, 4'h2, 16'h0612, 1'b1);
        pressKey("key3", 4'hE, 4'hB, 4'h3, 16'h6123, 1'b1);
        pressKey("key4", 4'hD, 4'hE, 4'h4, 16'h1234, 1'b1);
        pressKey("key5", 4'hD, 4'hD, 4'h5, 16'h2345, 1'b1);
        pressKey("star", 4'h7, 4'hE, 4'hE, 16'h0000, 1'b1);

        // Rows 0 and 2 together on column 0: row 0 wins, key stays held.
        pressKey("multi", 4'hA, 4'hE, 4'h1, 16'h0001, 1'b0);
        applyStimulus(4'hA, 1);
        checkOutput("multi hold", 4'hE, 4'h1, 1'b0, 1'b1, 16'h0001);

        // Reset while held.
        p0 = pulseCount;
        reset_n = 1'b0;
        #2;
        checkOutput("reset held", 4'hE, 4'h0, 1'b0, 1'b0, 16'h0000);
        row = 4'hF;
        repeat (2) @(negedge clk);
        #1;
        reset_n = 1'b1;
        applyStimulus(4'hF, 1);
        checkOutput("after reset held", 4'hD, 4'h0, 1'b0, 1'b0, 16'h0000);
        checkField("reset held pulses", 16'(pulseCount - p0), 16'd0);

        // Reset while debouncing '2' (row 0 on column 1).
        applyStimulus(4'hE, 2);
        checkOutput("debounce", 4'hD, 4'h0, 1'b0, 1'b0, 16'h0000);
        p0 = pulseCount;
        reset_n = 1'b0;
        #2;
        checkOutput("reset debounce", 4'hE, 4'h0, 1'b0, 1'b0, 16'h0000);
        row = 4'hF;
        repeat (2) @(negedge clk);
        #1;
        reset_n = 1'b1;
        applyStimulus(4'hF, 1);
        checkOutput("after reset debounce", 4'hD, 4'h0, 1'b0, 1'b0, 16'h0000);
        checkField("reset debounce pulses", 16'(pulseCount - p0), 16'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
